// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic-library types and limits
package arith_pkg;

  localparam int HA_MAX_LATENCY = 4;

  typedef struct packed {
    logic sum;
    logic carry;
  } ha_res_t;

endpackage

// File: rtl/half_adder_cell.sv
// rtl/half_adder_cell.sv - combinational 1-bit half adder
module half_adder_cell (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - registered lane-parallel half adder with valid pipeline
module half_adder
  import arith_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o,
  output logic             valid_o
);

  if (LATENCY < 1 || LATENCY > HA_MAX_LATENCY) begin : g_bad_latency
    $error("half_adder: LATENCY must be in 1..%0d", HA_MAX_LATENCY);
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("half_adder: WIDTH must be >= 1");
  end

  typedef struct packed {
    logic                  valid;
    ha_res_t [WIDTH-1:0]   res;
  } stage_t;

  ha_res_t [WIDTH-1:0]   res_comb;
  stage_t  [LATENCY-1:0] stage_q;
  stage_t  [LATENCY-1:0] stage_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a_i     (a_i[i]),
      .b_i     (b_i[i]),
      .sum_o   (res_comb[i].sum),
      .carry_o (res_comb[i].carry)
    );
  end

  // Stage 0 data only loads on valid so idle cycles keep the last result visible downstream.
  always_comb begin
    stage_d          = stage_q;
    stage_d[0].valid = valid_i;
    if (valid_i) begin
      stage_d[0].res = res_comb;
    end
    for (int s = 1; s < LATENCY; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign valid_o = stage_q[LATENCY-1].valid;

  for (genvar i = 0; i < WIDTH; i++) begin : g_out
    assign sum_o[i]   = stage_q[LATENCY-1].res[i].sum;
    assign carry_o[i] = stage_q[LATENCY-1].res[i].carry;
  end

endmodule

// File: tb/tb_half_adder.sv
// tb/tb_half_adder.sv - directed self-checking bench for half_adder
module tb_half_adder;

  logic       clk;
  logic       rst;
  logic       v_a, v_b;
  logic [0:0] a_a, b_a;
  logic [3:0] a_b, b_b;
  logic [0:0] sum_a, carry_a;
  logic [3:0] sum_b, carry_b;
  logic       vo_a, vo_b;

  int n_checks = 0;
  int n_errors = 0;

  half_adder #(.WIDTH(1), .LATENCY(1)) u_dut_a (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (v_a),
    .a_i     (a_a),
    .b_i     (b_a),
    .sum_o   (sum_a),
    .carry_o (carry_a),
    .valid_o (vo_a)
  );

  half_adder #(.WIDTH(4), .LATENCY(3)) u_dut_b (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (v_b),
    .a_i     (a_b),
    .b_i     (b_b),
    .sum_o   (sum_b),
    .carry_o (carry_b),
    .valid_o (vo_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single pulse into the LATENCY=3 instance; inputs change while idle to prove holding.
  task automatic pulse_b(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] es, input logic [3:0] ec);
    a_b = a; b_b = b; v_b = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      v_b = 1'b0; a_b = ~a; b_b = ~b;
      check_val($sformatf("%s_valid_c%0d", tag, c), {31'd0, vo_b}, {31'd0, c == 3});
      if (c >= 3) begin
        check_val($sformatf("%s_sum_c%0d", tag, c), {28'd0, sum_b}, {28'd0, es});
        check_val($sformatf("%s_carry_c%0d", tag, c), {28'd0, carry_b}, {28'd0, ec});
      end
    end
  endtask

  logic [3:0] exp_sum_tbl;
  logic [3:0] exp_carry_tbl;
  logic [3:0] bb_a   [3];
  logic [3:0] bb_b   [3];
  logic [3:0] bb_sum [3];
  logic [3:0] bb_car [3];

  initial begin
    rst = 1'b1; v_a = 1'b0; v_b = 1'b0;
    a_a = '0; b_a = '0; a_b = '0; b_b = '0;
    exp_sum_tbl   = 4'b0110;
    exp_carry_tbl = 4'b1000;
    bb_a[0] = 4'b0101; bb_b[0] = 4'b0011; bb_sum[0] = 4'b0110; bb_car[0] = 4'b0001;
    bb_a[1] = 4'b1001; bb_b[1] = 4'b1100; bb_sum[1] = 4'b0101; bb_car[1] = 4'b1000;
    bb_a[2] = 4'b0110; bb_b[2] = 4'b0111; bb_sum[2] = 4'b0001; bb_car[2] = 4'b0110;

    // Reset for two cycles then release.
    tick();
    tick();
    check_val("rst_hold_valid_a", {31'd0, vo_a}, 32'd0);
    check_val("rst_hold_valid_b", {31'd0, vo_b}, 32'd0);
    rst = 1'b0;
    tick();
    check_val("rst_sum_a", {31'd0, sum_a}, 32'd0);
    check_val("rst_carry_a", {31'd0, carry_a}, 32'd0);
    check_val("rst_valid_a", {31'd0, vo_a}, 32'd0);
    check_val("rst_sum_b", {28'd0, sum_b}, 32'd0);
    check_val("rst_carry_b", {28'd0, carry_b}, 32'd0);
    check_val("rst_valid_b", {31'd0, vo_b}, 32'd0);

    // Truth table, back-to-back on the one-lane, one-stage instance.
    for (int k = 0; k < 4; k++) begin
      a_a = k[1]; b_a = k[0]; v_a = 1'b1;
      tick();
      check_val($sformatf("tt_sum_%0d", k), {31'd0, sum_a}, {31'd0, exp_sum_tbl[k]});
      check_val($sformatf("tt_carry_%0d", k), {31'd0, carry_a}, {31'd0, exp_carry_tbl[k]});
      check_val($sformatf("tt_valid_%0d", k), {31'd0, vo_a}, 32'd1);
    end

    // Valid 01, then idle with changing operands: result must hold.
    a_a = 1'b0; b_a = 1'b1; v_a = 1'b1;
    tick();
    check_val("hold_first_valid", {31'd0, vo_a}, 32'd1);
    check_val("hold_first_sum", {31'd0, sum_a}, 32'd1);
    v_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_a = ~k[0]; b_a = ~k[1];
      tick();
      check_val($sformatf("hold_valid_%0d", k), {31'd0, vo_a}, 32'd0);
      check_val($sformatf("hold_sum_%0d", k), {31'd0, sum_a}, 32'd1);
      check_val($sformatf("hold_carry_%0d", k), {31'd0, carry_a}, 32'd0);
    end

    // Four lanes, three stages.
    pulse_b("lanes", 4'b1100, 4'b1010, 4'b0110, 4'b1000);
    pulse_b("all11", 4'b1111, 4'b1111, 4'b0000, 4'b1111);

    // Full throughput: three consecutive operand pairs.
    for (int k = 0; k < 3; k++) begin
      a_b = bb_a[k]; b_b = bb_b[k]; v_b = 1'b1;
      tick();
      check_val($sformatf("b2b_fill_valid_%0d", k), {31'd0, vo_b}, {31'd0, k == 2});
    end
    v_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      check_val($sformatf("b2b_valid_%0d", k), {31'd0, vo_b}, 32'd1);
      check_val($sformatf("b2b_sum_%0d", k), {28'd0, sum_b}, {28'd0, bb_sum[k]});
      check_val($sformatf("b2b_carry_%0d", k), {28'd0, carry_b}, {28'd0, bb_car[k]});
    end
    tick();
    check_val("b2b_after_valid", {31'd0, vo_b}, 32'd0);
    check_val("b2b_after_sum", {28'd0, sum_b}, {28'd0, bb_sum[2]});

    // Two results in flight, then a one-cycle reset with valid_i still high.
    a_b = 4'b1111; b_b = 4'b0000; v_b = 1'b1;
    tick();
    a_b = 4'b0011; b_b = 4'b0011;
    tick();
    rst = 1'b1; a_b = 4'b1111; b_b = 4'b1111;
    tick();
    check_val("flush_rst_valid", {31'd0, vo_b}, 32'd0);
    check_val("flush_rst_sum", {28'd0, sum_b}, 32'd0);
    check_val("flush_rst_carry", {28'd0, carry_b}, 32'd0);
    rst = 1'b0; v_b = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_val($sformatf("flush_valid_%0d", c), {31'd0, vo_b}, 32'd0);
      check_val($sformatf("flush_sum_%0d", c), {28'd0, sum_b}, 32'd0);
      check_val($sformatf("flush_carry_%0d", c), {28'd0, carry_b}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
